// File: rtl/mac_stream_ctrl_if.sv
// Handshake and datapath bundle between the MAC stream controller, layer buffers, MAC and layer controller.
// master is the controller's view; slave is the surrounding environment's view.
interface mac_stream_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int ACC_W  = 26
);
  logic              start;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_pixels;
  logic [127:0]      mem_weights;
  logic [127:0]      mac_pixels;
  logic [127:0]      mac_weights;
  logic [19:0]       mac_sum;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    input  start, mem_pixels, mem_weights, mac_sum, result_ready,
    output busy, mem_rd_en, mem_addr, mac_pixels, mac_weights, result, result_valid
  );

  modport slave (
    output start, mem_pixels, mem_weights, mac_sum, result_ready,
    input  busy, mem_rd_en, mem_addr, mac_pixels, mac_weights, result, result_valid
  );
endinterface

// File: rtl/mac_stream_ctrl.sv
// Streams N_BEATS pixel/weight words into the MAC and accumulates its sums; result_valid after N_BEATS+MAC_LAT+2 edges.
// No stalls on the fetch side; the finished result is held in HOLD until result_ready.
module mac_stream_ctrl #(
  parameter int N_BEATS = 49,
  parameter int ADDR_W  = 6,
  parameter int MAC_LAT = 3,
  parameter int ACC_W   = 26
) (
  input logic             clk,
  input logic             rst,
  mac_stream_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  // buffer read stage + operand register stage + MAC pipeline
  localparam int TAG_N = MAC_LAT + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BEATS - 1);
  localparam logic [TAG_N-1:0]  TAG_LAST  = {1'b1, {(TAG_N-1){1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [TAG_N-1:0]  tag_q;
  logic [127:0]      pix_q, wgt_q;
  logic [ACC_W-1:0]  acc_q;
  logic              rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    rd_en            = 1'b0;
    bus.busy         = 1'b1;
    bus.result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        // last beat leaves the pipe on this edge, so HOLD sees its sum
        if (tag_q == TAG_LAST) state_d = HOLD;
      end
      HOLD: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      tag_q  <= '0;
      pix_q  <= '0;
      wgt_q  <= '0;
      acc_q  <= '0;
    end else begin
      tag_q <= {tag_q[TAG_N-2:0], rd_en};

      if (tag_q[0]) begin
        pix_q <= bus.mem_pixels;
        wgt_q <= bus.mem_weights;
      end else begin
        pix_q <= '0;
        wgt_q <= '0;
      end

      if (state_q == FETCH && addr_q != LAST_ADDR)
        addr_q <= addr_q + ADDR_W'(1);
      else if (state_q == HOLD && bus.result_ready)
        addr_q <= '0;

      if (state_q == IDLE && bus.start)
        acc_q <= '0;
      else if (tag_q[TAG_N-1])
        acc_q <= acc_q + {{(ACC_W-20){1'b0}}, bus.mac_sum};
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_addr    = addr_q;
  assign bus.mac_pixels  = pix_q;
  assign bus.mac_weights = wgt_q;
  assign bus.result      = acc_q;

endmodule
